// File: rtl/z80_busack_ctrl.sv
// z80_busack_ctrl: CPU-side Z80 bus request/acknowledge responder with tri-state bus drivers
//
// Optional feature macro: BUSRQ_SYNC_EN. When defined, i_nbusrq passes a 2-flop
// synchronizer. When undefined, it passes one registered stage, which is only
// safe for a master on the same clock.
//
// Parameters:
//   TURNAROUND   clocks spent floated with o_nbusak high before the grant (>=1)
//   RECLAIM_DLY  clocks spent floated with o_nbusak high after the release (>=1)
// Ports:
//   i_clock        system clock, rising edge
//   i_nreset       asynchronous active-low reset
//   i_nbusrq       bus request from the external master, active low, asynchronous
//   o_nbusak       bus acknowledge, active low, registered
//   i_cpu_busy     CPU M-cycle in progress
//   o_cpu_hold     CPU must not start a new M-cycle
//   i_cpu_addr     CPU address
//   i_cpu_dout     CPU write data
//   i_cpu_dout_en  CPU wants to drive DQ
//   i_cpu_rd_n     CPU read strobe
//   i_cpu_wr_n     CPU write strobe
//   o_cpu_din      DQ as seen on the bus, also during grant for snooping
//   io_addr        system address bus
//   io_dq          system data bus
//   io_nrd         system read strobe
//   io_nwr         system write strobe
module z80_busack_ctrl #(
  parameter int TURNAROUND  = 1,
  parameter int RECLAIM_DLY = 1
) (
  input  logic        i_clock,
  input  logic        i_nreset,
  input  logic        i_nbusrq,
  output logic        o_nbusak,
  input  logic        i_cpu_busy,
  output logic        o_cpu_hold,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_dout,
  input  logic        i_cpu_dout_en,
  input  logic        i_cpu_rd_n,
  input  logic        i_cpu_wr_n,
  output logic [7:0]  o_cpu_din,
  inout  wire  [15:0] io_addr,
  inout  wire  [7:0]  io_dq,
  inout  wire         io_nrd,
  inout  wire         io_nwr
);
  localparam int MAXD = TURNAROUND > RECLAIM_DLY ? TURNAROUND : RECLAIM_DLY;
  localparam int CW = $clog2(MAXD + 1);
  typedef enum logic [2:0] {RUN, DRAIN, FLOAT, GRANT, RECLAIM} state_t;
  state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic r_sync1, r_nbusak, r_drv, w_busrq_s, w_ta_done, w_rd_done;
`ifdef BUSRQ_SYNC_EN
  logic r_sync2;
  always_ff @(posedge i_clock or negedge i_nreset)
    if (!i_nreset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_nbusrq;
      r_sync2 <= r_sync1;
    end
  assign w_busrq_s = r_sync2;
`else
  always_ff @(posedge i_clock or negedge i_nreset)
    if (!i_nreset) r_sync1 <= 1'b1;
    else r_sync1 <= i_nbusrq;
  assign w_busrq_s = r_sync1;
`endif
  assign w_ta_done = r_cnt == CW'(TURNAROUND - 1);
  assign w_rd_done = r_cnt == CW'(RECLAIM_DLY - 1);
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      RUN:     if (!w_busrq_s) w_nxt = i_cpu_busy ? DRAIN : FLOAT;
      DRAIN:   w_nxt = w_busrq_s ? RUN : (i_cpu_busy ? DRAIN : FLOAT);
      FLOAT:   w_nxt = w_busrq_s ? RECLAIM : (w_ta_done ? GRANT : FLOAT);
      GRANT:   if (w_busrq_s) w_nxt = RECLAIM;
      RECLAIM: if (w_rd_done) w_nxt = RUN;
      default: w_nxt = RUN;
    endcase
  end
  // Acknowledge and drive enable are both registered from the next state, so
  // they can never be active together.
  always_ff @(posedge i_clock or negedge i_nreset)
    if (!i_nreset) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_nbusak <= 1'b1;
      r_drv    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= (w_nxt != r_state || !(r_state inside {FLOAT, RECLAIM})) ? '0 : r_cnt + 1'b1;
      r_nbusak <= w_nxt != GRANT;
      r_drv    <= w_nxt inside {RUN, DRAIN};
    end
  assign o_nbusak   = r_nbusak;
  assign o_cpu_hold = (r_state != RUN) | ~w_busrq_s;
  assign io_addr    = r_drv ? i_cpu_addr : 'z;
  assign io_nrd     = r_drv ? i_cpu_rd_n : 1'bz;
  assign io_nwr     = r_drv ? i_cpu_wr_n : 1'bz;
  assign io_dq      = (r_drv & i_cpu_dout_en) ? i_cpu_dout : 'z;
  assign o_cpu_din  = io_dq;
endmodule

// File: tb/tb_z80_busack_ctrl.sv
// tb_z80_busack_ctrl: randomized directed bench for z80_busack_ctrl
module tb_z80_busack_ctrl;
  localparam int TA = 2;
  localparam int RD = 2;
`ifdef BUSRQ_SYNC_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif
  logic clk = 0, nreset = 1, nbusrq = 1, cpu_busy = 0, dout_en = 0, rd_n = 1, wr_n = 1;
  logic [15:0] cpu_addr = 0, m_addr = 0;
  logic [7:0] cpu_dout = 0, m_dq = 0;
  logic m_en_a = 0, m_en_d = 0;
  wire nbusak, cpu_hold, nrd, nwr;
  wire [7:0] cpu_din, dq;
  wire [15:0] addr;
  int n_run = 0, n_fail = 0;
  // The bench plays the external master; it drives complements of the CPU
  // values so any overlap with a DUT driver corrupts what is read back.
  assign addr = m_en_a ? m_addr : 'z;
  assign nrd  = m_en_a ? ~rd_n : 1'bz;
  assign nwr  = m_en_a ? ~wr_n : 1'bz;
  assign dq   = m_en_d ? m_dq : 'z;
  always #5 clk = ~clk;
  z80_busack_ctrl #(.TURNAROUND(TA), .RECLAIM_DLY(RD)) dut (
    .i_clock(clk), .i_nreset(nreset), .i_nbusrq(nbusrq), .o_nbusak(nbusak),
    .i_cpu_busy(cpu_busy), .o_cpu_hold(cpu_hold), .i_cpu_addr(cpu_addr),
    .i_cpu_dout(cpu_dout), .i_cpu_dout_en(dout_en), .i_cpu_rd_n(rd_n),
    .i_cpu_wr_n(wr_n), .o_cpu_din(cpu_din), .io_addr(addr), .io_dq(dq),
    .io_nrd(nrd), .io_nwr(nwr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rnd();
    cpu_addr = 16'($urandom);
    m_addr   = ~cpu_addr;
    rd_n     = 1'($urandom);
    wr_n     = ~rd_n;
    m_dq     = 8'($urandom);
    cpu_dout = ~m_dq;
  endtask
  task automatic chk_cpu(input string tag);
    chk(tag, {addr, nrd, nwr}, {cpu_addr, rd_n, wr_n});
  endtask
  task automatic chk_mst(input string tag);
    chk(tag, {addr, nrd, nwr}, {m_addr, ~rd_n, ~wr_n});
  endtask
  // Request at edge k=1. busrq_s is seen low after edge 1+L; with the CPU busy
  // for b more edges the drivers drop at edge 2+L+b, and the grant follows TA
  // edges later. The grant is then held for h edges.
  task automatic do_grant(input int b, input int h);
    int t_off, t_gnt;
    t_off = 2 + L + b;
    t_gnt = t_off + TA;
    dout_en = 1;
    cpu_busy = b > 0;
    nbusrq = 0;
    for (int k = 1; k <= t_gnt + h; k++) begin
      step();
      chk("ack", nbusak, k < t_gnt);
      chk("hold", cpu_hold, k >= 1 + L);
      if (k < t_off) chk_cpu("drain_drv");
      else begin
        chk_mst("float");
        chk("snoop", cpu_din, m_dq);
      end
      if (k == 1 + L + b) cpu_busy = 0;
      if (k == t_off - 1) begin
        m_en_a = 1;
        m_en_d = 1;
      end
    end
  endtask
  // Release at edge j=1: acknowledge rises at 2+L, drivers return RD edges later.
  task automatic do_release();
    nbusrq = 1;
    for (int j = 1; j <= 3 + L + RD; j++) begin
      step();
      chk("rel_ack", nbusak, j >= 2 + L);
      chk("rel_hold", cpu_hold, j < 2 + L + RD);
      if (j < 2 + L + RD) chk_mst("reclaim");
      else begin
        chk_cpu("redrive");
        chk("redrive_dq", cpu_din, cpu_dout);
      end
      if (j == 1 + L + RD) begin
        m_en_a = 0;
        m_en_d = 0;
      end
    end
  endtask
  initial begin
    rnd();
    #2 nreset = 0;
    m_en_a = 1;
    m_en_d = 1;
    step();
    step();
    chk("rst_ack", nbusak, 1);
    chk_mst("rst_z");
    chk("rst_dq_z", cpu_din, m_dq);
    m_en_a = 0;
    m_en_d = 0;
    cpu_addr = 16'h1234;
    nreset = 1;
    step();
    chk_cpu("rst_rel");
    chk("rst_rel_ack", nbusak, 1);
    chk("rst_rel_hold", cpu_hold, 0);
    dout_en = 0;
    m_en_d = 1;
    step();
    chk("dq_in", cpu_din, m_dq);
    m_en_d = 0;
    dout_en = 1;
    step();
    chk("dq_out", dq, cpu_dout);
    for (int i = 0; i < 3; i++) begin
      rnd();
      do_grant(0, int'($urandom_range(1, 5)));
      do_release();
    end
    for (int i = 0; i < 3; i++) begin
      rnd();
      do_grant(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)));
      do_release();
    end
    rnd();
    cpu_busy = 1;
    nbusrq = 0;
    for (int k = 1; k <= 5 + L; k++) begin
      step();
      chk("pulse_ack", nbusak, 1);
      chk_cpu("pulse_drv");
      chk("pulse_hold", cpu_hold, k == 1 + L || k == 2 + L);
      nbusrq = 1;
    end
    cpu_busy = 0;
    rnd();
    do_grant(0, 2);
    nreset = 0;
    #1;
    chk("arst_ack", nbusak, 1);
    chk_mst("arst_z");
    nbusrq = 1;
    step();
    chk_mst("arst_z_hold");
    chk("arst_ack_hold", nbusak, 1);
    m_en_a = 0;
    m_en_d = 0;
    nreset = 1;
    step();
    chk_cpu("arst_rel");
    chk("arst_rel_ack", nbusak, 1);
    chk("arst_rel_hold", cpu_hold, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
